// File: rtl/pulse_width_meter.sv
// pulse_width_meter
//   Synchronizes an asynchronous level (D) into the CK domain, flags its
//   rising/falling edges and measures every high pulse in whole CK cycles.
//   Each measurement is offered on a valid/ready port and held until taken.
//
// Parameters
//   W     : width of the pulse counter and of WIDTH
//   SYNC  : number of synchronizer flops (>= 2)
//
// Ports
//   CK       in   clock, rising edge
//   RESET_N  in   asynchronous active-low reset
//   D        in   level to measure, asynchronous to CK
//   CLR      in   synchronous clear (FSM, result, DROP); synchronizer keeps tracking
//   READY    in   consumer accepts the held result
//   VALID    out  a result is held on WIDTH/OVF
//   WIDTH    out  measured high-pulse length in cycles (saturating)
//   OVF      out  held result saturated
//   DROP     out  sticky: a pulse started while a result was still pending
//   RISE     out  one-cycle flag on a synchronized rising edge
//   FALL     out  one-cycle flag on a synchronized falling edge
module pulse_width_meter #(
  parameter int unsigned W    = 8,
  parameter int unsigned SYNC = 2
) (
  input  logic         CK,
  input  logic         RESET_N,
  input  logic         D,
  input  logic         CLR,
  input  logic         READY,
  output logic         VALID,
  output logic [W-1:0] WIDTH,
  output logic         OVF,
  output logic         DROP,
  output logic         RISE,
  output logic         FALL
);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    HOLD
  } state_e;

  state_e          state_q, state_d;

  logic [SYNC-1:0] sync_q, sync_d;
  logic            dp_q, dp_d;
  logic [W-1:0]    cnt_q, cnt_d;
  logic            ovf_i_q, ovf_i_d;
  logic [W-1:0]    width_q, width_d;
  logic            ovf_q, ovf_d;
  logic            valid_q, valid_d;
  logic            drop_q, drop_d;

  logic            ds;
  logic            rise;
  logic            fall;
  logic            handshake;

  // Synchronizer and one-cycle delay; untouched by CLR so edge decode keeps tracking.
  assign ds = sync_q[SYNC-1];

  always_comb begin
    sync_d = {sync_q[SYNC-2:0], D};
    dp_d   = ds;
  end

  always_ff @(posedge CK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q <= '0;
      dp_q   <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dp_q   <= dp_d;
    end
  end

  // Edge decode from flops only, so RISE/FALL are glitch-free.
  assign rise      = ds & ~dp_q;
  assign fall      = ~ds & dp_q;
  assign handshake = valid_q & READY;

  // State register (FSM plus the measurement/result registers it controls).
  always_ff @(posedge CK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_i_q <= 1'b0;
      width_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_i_q <= ovf_i_d;
      width_q <= width_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state logic; CLR wins over every transition.
  always_comb begin
    state_d = state_q;
    if (CLR) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (rise) state_d = MEASURE;
        MEASURE: if (fall) state_d = HOLD;
        HOLD: begin
          // A rise coinciding with the handshake starts the next pulse directly.
          if (handshake) state_d = rise ? MEASURE : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output / datapath logic.
  always_comb begin
    cnt_d   = cnt_q;
    ovf_i_d = ovf_i_q;
    width_d = width_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    drop_d  = drop_q;
    if (CLR) begin
      cnt_d   = '0;
      ovf_i_d = 1'b0;
      width_d = '0;
      ovf_d   = 1'b0;
      valid_d = 1'b0;
      drop_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            cnt_d   = W'(1);
            ovf_i_d = 1'b0;
          end
        end
        MEASURE: begin
          if (ds) begin
            // Saturate; an attempted step past all-ones records the overflow.
            if (cnt_q == '1) ovf_i_d = 1'b1;
            else             cnt_d   = cnt_q + W'(1);
          end else if (fall) begin
            width_d = cnt_q;
            ovf_d   = ovf_i_q;
            valid_d = 1'b1;
          end
        end
        HOLD: begin
          if (handshake) begin
            valid_d = 1'b0;
            ovf_i_d = 1'b0;
            if (rise) cnt_d = W'(1);
          end else if (rise) begin
            drop_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign VALID = valid_q;
  assign WIDTH = width_q;
  assign OVF   = ovf_q;
  assign DROP  = drop_q;
  assign RISE  = rise;
  assign FALL  = fall;

endmodule

// File: tb/tb_pulse_width_meter.sv
module tb_pulse_width_meter;

  localparam int unsigned W    = 4;
  localparam int unsigned SYNC = 2;

  logic         CK = 1'b0;
  logic         RESET_N;
  logic         D;
  logic         CLR;
  logic         READY;
  logic         VALID;
  logic [W-1:0] WIDTH;
  logic         OVF;
  logic         DROP;
  logic         RISE;
  logic         FALL;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #10 CK = ~CK;

  pulse_width_meter #(
    .W    (W),
    .SYNC (SYNC)
  ) dut (
    .CK      (CK),
    .RESET_N (RESET_N),
    .D       (D),
    .CLR     (CLR),
    .READY   (READY),
    .VALID   (VALID),
    .WIDTH   (WIDTH),
    .OVF     (OVF),
    .DROP    (DROP),
    .RISE    (RISE),
    .FALL    (FALL)
  );

  // ---------------- reference model (pulse-level) ----------------
  bit hist[$];          // D as sampled at each rising edge, newest last
  bit m_meas, m_pend, m_drop, m_ovf, m_rise, m_fall;
  int m_run, m_width;

  // D sampled k edges ago (k = 0: most recent edge)
  function automatic bit dsamp(input int k);
    if (k < hist.size()) return hist[hist.size() - 1 - k];
    return 1'b0;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_meas = 0; m_pend = 0; m_drop = 0; m_ovf = 0;
    m_rise = 0; m_fall = 0; m_run = 0; m_width = 0;
  endtask

  task automatic model_edge(input bit d, input bit rdy, input bit clr);
    bit ds_pre, dp_pre, rs, fl, hs;
    int maxv;
    maxv   = (1 << W) - 1;
    ds_pre = dsamp(SYNC - 1);
    dp_pre = dsamp(SYNC);
    rs     = ds_pre & ~dp_pre;
    fl     = ~ds_pre & dp_pre;
    if (clr) begin
      m_meas = 0; m_pend = 0; m_drop = 0; m_width = 0; m_ovf = 0; m_run = 0;
    end else begin
      hs = m_pend && rdy;
      if (m_pend && !hs && rs) m_drop = 1;
      if (hs) m_pend = 0;
      if (m_meas) begin
        if (ds_pre) m_run++;
        else if (fl) begin
          m_pend  = 1;
          m_meas  = 0;
          m_width = (m_run > maxv) ? maxv : m_run;
          m_ovf   = (m_run > maxv);
        end
      end else if (!m_pend && rs) begin
        m_meas = 1;
        m_run  = 1;
      end
    end
    hist.push_back(d);
    if (hist.size() > 8) void'(hist.pop_front());
    m_rise = dsamp(SYNC - 1) & ~dsamp(SYNC);
    m_fall = ~dsamp(SYNC - 1) & dsamp(SYNC);
  endtask

  function automatic logic [8:0] dut_vec();
    return {VALID, WIDTH, OVF, DROP, RISE, FALL};
  endfunction

  function automatic logic [8:0] model_vec();
    return {m_pend, W'(m_width), m_ovf, m_drop, m_rise, m_fall};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample 1 ns after the rising edge.
  task automatic step(input bit d, input bit rdy, input bit clr);
    @(negedge CK);
    D = d; READY = rdy; CLR = clr;
    @(posedge CK);
    model_edge(d, rdy, clr);
    cyc++;
    #1;
    check($sformatf("step%0d", cyc), dut_vec(), model_vec());
  endtask

  task automatic wait_valid(input string name, input int expw, input bit expo, input bit rdy);
    bit seen;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1'b0, rdy, 1'b0);
      if (VALID === 1'b1) seen = 1;
    end
    check({name, "_valid"}, seen, 1);
    if (seen) begin
      check({name, "_width"}, WIDTH, expw);
      check({name, "_ovf"}, OVF, expo);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         d;
    logic         rdy;
    logic         clr;
    logic         valid;
    logic [W-1:0] width;
    logic         ovf;
    logic         drop;
    logic         rise;
    logic         fall;
  } vec_t;

  function automatic vec_t mk(input logic d, input logic v, input int w,
                              input logic r, input logic f);
    vec_t t;
    t.d = d; t.rdy = 1'b1; t.clr = 1'b0;
    t.valid = v; t.width = W'(w); t.ovf = 1'b0; t.drop = 1'b0;
    t.rise = r; t.fall = f;
    return t;
  endfunction

  vec_t tbl[13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit lvl;
    bit vseen;
    int len;

    // 5 idle cycles, then D high for 3 samples, READY held high
    tbl[0]  = mk(0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 0, 0, 0, 0);
    tbl[6]  = mk(1, 0, 0, 1, 0);
    tbl[7]  = mk(1, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 1);
    tbl[10] = mk(0, 1, 3, 0, 0);
    tbl[11] = mk(0, 0, 3, 0, 0);
    tbl[12] = mk(0, 0, 3, 0, 0);

    RESET_N = 1'b0; D = 1'b0; CLR = 1'b0; READY = 1'b1;
    model_reset();
    #25;
    check("reset_state", dut_vec(), 0);
    @(posedge CK);
    #1 RESET_N = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge CK);
      D = tbl[i].d; READY = tbl[i].rdy; CLR = tbl[i].clr;
      @(posedge CK);
      model_edge(tbl[i].d, tbl[i].rdy, tbl[i].clr);
      cyc++;
      #1;
      check($sformatf("tbl%0d", i), dut_vec(),
            {tbl[i].valid, tbl[i].width, tbl[i].ovf, tbl[i].drop, tbl[i].rise, tbl[i].fall});
    end

    // Saturation: 20-cycle pulse on a 4-bit counter, then a 2-cycle pulse
    for (int i = 0; i < 20; i++) step(1, 1, 0);
    wait_valid("sat", 15, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) step(1, 1, 0);
    wait_valid("short", 2, 1'b0, 1'b1);

    // Drop: READY low, pulses of 4 and 6
    repeat (3) step(0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    check("drop_valid", VALID, 1);
    check("drop_width", WIDTH, 4);
    check("drop_flag", DROP, 1);
    step(0, 1, 0);
    check("drop_hs_valid", VALID, 0);
    check("drop_sticky", DROP, 1);

    // CLR mid-measurement
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    step(1, 1, 1);
    check("clr_valid", VALID, 0);
    check("clr_drop", DROP, 0);
    vseen = 0;
    for (int i = 0; i < 2; i++) begin step(1, 1, 0); vseen |= VALID; end
    for (int i = 0; i < 6; i++) begin step(0, 1, 0); vseen |= VALID; end
    check("clr_noresult", vseen, 0);

    // Handshake in the same cycle as the next RISE
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    check("rr_hold", VALID, 1);
    for (int i = 0; i < 5; i++) step(1, m_rise, 0);
    wait_valid("rr", 5, 1'b0, 1'b1);
    check("rr_nodrop", DROP, 0);

    // Randomized runs against the model
    lvl = 0;
    for (int r = 0; r < 30; r++) begin
      lvl = ~lvl;
      len = $urandom_range(1, 20);
      for (int j = 0; j < len; j++)
        step(lvl, ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0));
    end

    // Asynchronous reset while a result is held
    repeat (4) step(0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    check("arst_hold", VALID, 1);
    @(negedge CK);
    #2 RESET_N = 1'b0;
    #1;
    check("arst_outputs", dut_vec(), 0);
    model_reset();
    @(posedge CK);
    #1 RESET_N = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    wait_valid("post_rst", 3, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
